// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate truth-table sequencer: FSM encoding,
// vector count and vector index width.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned VEC_COUNT = 4;
  localparam int unsigned IDX_W     = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Settle countdown: loaded with the wait length, flags the last wait cycle
// so the sequencer leaves SETTLE after exactly load_val cycles.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = (cnt == 4'd1);

endmodule

// File: rtl/gate_test_sequencer.sv
// Drives the four {a,b} vectors into a 2-input gate, compares against a
// latched truth table and reports pass/err_count/fail_mask.
// Optional trace outputs: define GATE_SEQ_TRACE_EN.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] exp_tt,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
`ifdef GATE_SEQ_TRACE_EN
  ,
  output logic       first_fail_vld,
  output logic [1:0] first_fail_idx
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic [3:0]       exp_q;
  logic             tmr_load;
  logic             tmr_expired;
  logic             start_acc;
  logic             abort_act;
  logic             mismatch;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (4'(SETTLE_CYCLES)),
    .expired  (tmr_expired)
  );

  // abort outranks start even in IDLE; on its own it only acts when busy
  assign start_acc = (state_q == IDLE) && start && !abort;
  assign abort_act = (state_q != IDLE) && abort;
  assign mismatch  = (dut_y != exp_q[idx]);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_expired) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (idx == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_act) begin
      state_d  = IDLE;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      exp_q     <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_mask <= '0;
    end else begin
      done <= 1'b0;
      if (abort_act) begin
        dut_a <= 1'b0;
        dut_b <= 1'b0;
        pass  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_acc) begin
              exp_q     <= exp_tt;
              err_count <= '0;
              fail_mask <= '0;
              idx       <= '0;
              dut_a     <= 1'b0;
              dut_b     <= 1'b0;
            end
          end
          SAMPLE: begin
            if (mismatch) begin
              fail_mask[idx] <= 1'b1;
              if (err_count != 3'(VEC_COUNT)) err_count <= err_count + 3'd1;
            end
            if (idx != LAST_IDX) begin
              idx            <= idx + 2'd1;
              {dut_a, dut_b} <= idx + 2'd1;
            end
          end
          DONE: begin
            done  <= 1'b1;
            pass  <= (err_count == '0);
            dut_a <= 1'b0;
            dut_b <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GATE_SEQ_TRACE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else if (start_acc) begin
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else if ((state_q == SAMPLE) && !abort && mismatch && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_idx <= idx;
    end
  end
`endif

endmodule
